// File: rtl/uart_tx_frame.sv
// uart_tx_frame: UART transmit framer, one bit per clk cycle.
//
// A byte is accepted with a single-cycle data_valid while busy is low. It is sent LSB first
// as a start bit (0), DATA_WIDTH data bits, an optional parity bit and one stop bit (1).
//
// Ports:
//   clk         bit-rate clock, rising edge
//   rst         synchronous active-high reset
//   p_data      parallel data, latched on the accept edge
//   data_valid  send request, ignored while busy
//   par_en      1 = append parity bit, latched on the accept edge
//   par_typ     0 = even, 1 = odd parity, latched on the accept edge
//   tx_out      registered serial line, idles high
//   busy        registered, high from the start bit through the stop bit
module uart_tx_frame #(
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] p_data,
  input  logic                  data_valid,
  input  logic                  par_en,
  input  logic                  par_typ,
  output logic                  tx_out,
  output logic                  busy
);

  localparam int unsigned CntW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop
  } state_e;

  state_e                state_q;
  logic [CntW-1:0]       cnt_q;
  logic [DATA_WIDTH-1:0] data_q;
  logic                  par_en_q;
  logic                  par_typ_q;
  logic                  tx_q;
  logic                  busy_q;

  logic [CntW-1:0] cnt_inc;
  logic            par_bit;

  always_comb begin
    cnt_inc = cnt_q + 1'b1;
    // Even parity makes the total number of ones even; odd inverts it.
    par_bit = (^data_q) ^ par_typ_q;
  end

  // tx_q and busy_q are loaded with the value belonging to the state being entered, so the
  // line shows each bit for exactly the cycle its state is active.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      data_q    <= '0;
      par_en_q  <= 1'b0;
      par_typ_q <= 1'b0;
      tx_q      <= 1'b1;
      busy_q    <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          tx_q   <= 1'b1;
          busy_q <= 1'b0;
          if (data_valid) begin
            state_q   <= StStart;
            data_q    <= p_data;
            par_en_q  <= par_en;
            par_typ_q <= par_typ;
            cnt_q     <= '0;
            tx_q      <= 1'b0;
            busy_q    <= 1'b1;
          end
        end
        StStart: begin
          state_q <= StData;
          tx_q    <= data_q[0];
        end
        StData: begin
          if (cnt_q == CntLast) begin
            if (par_en_q) begin
              state_q <= StParity;
              tx_q    <= par_bit;
            end else begin
              state_q <= StStop;
              tx_q    <= 1'b1;
            end
          end else begin
            cnt_q <= cnt_inc;
            tx_q  <= data_q[cnt_inc];
          end
        end
        StParity: begin
          state_q <= StStop;
          tx_q    <= 1'b1;
        end
        StStop: begin
          // A request on this edge is dropped; it is picked up once back in idle.
          state_q <= StIdle;
          tx_q    <= 1'b1;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= StIdle;
          tx_q    <= 1'b1;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign tx_out = tx_q;
  assign busy   = busy_q;

endmodule
